// File: rtl/ss_frame_receiver.sv
// ss_frame_receiver: recognises start/data/parity/stop framed words on a serial line
// and presents each word in parallel with valid, parity and framing status.
module ss_frame_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in,
    input  logic                  lsb_first,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            frame_cnt
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0] bit_cnt;
    logic lsb_q, par_q, last_bit;
    assign last_bit = bit_cnt == CW'(DATA_WIDTH - 1);
    assign busy = state != IDLE;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (enable)
            case (state)
                IDLE:    state_nxt = in ? IDLE : DATA;
                DATA:    state_nxt = last_bit ? PARITY : DATA;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
    end
    // Strobes default low every edge so they last one clock even while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            lsb_q      <= 1'b0;
            par_q      <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (enable)
                case (state)
                    IDLE: if (!in) begin
                        lsb_q   <= lsb_first;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= lsb_q ? {in, shreg[DATA_WIDTH-1:1]} : {shreg[DATA_WIDTH-2:0], in};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_q <= in;
                    default: if (in) begin
                        data_out   <= shreg;
                        valid      <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        parity_err <= (^shreg ^ par_q) != PARITY_ODD;
                    end else begin
                        frame_err <= 1'b1;
                    end
                endcase
        end
    end
endmodule

// File: doc/ss_frame_receiver.md
Name: ss_frame_receiver

Overview:
Downstream stage of the serial-in/serial-out shift register. Consumes the one-bit serial stream at the register's output and recognises framed words: start bit, DATA_WIDTH data bits, parity bit, stop bit. Each received word is presented in parallel with a one-cycle valid strobe, parity and framing status, and a running frame count. Runs on the same clock, reset and enable as the shift register, one bit per enabled clock.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (2..16)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  bit-advance qualifier; all sampling occurs only on edges with enable=1
in  input  1  serial line; idle level 1
lsb_first  input  1  bit order for the frame; 1 = first data bit goes to data_out[0]
data_out  output  DATA_WIDTH  last accepted word
valid  output  1  one-cycle strobe: data_out/parity_err updated
parity_err  output  1  parity status of the word on data_out
frame_err  output  1  one-cycle strobe: stop bit sampled as 0
busy  output  1  high while a frame is in progress (state != IDLE)
frame_cnt  output  8  count of valid strobes, wraps 255 -> 0

Behaviour:
- Reset (async, reset=0): state=IDLE; data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, frame_cnt=0, shift register and bit counter cleared. Reset mid-frame aborts the frame with no strobe.
- States: IDLE, DATA, PARITY, STOP. Transitions happen only on edges with enable=1.
- IDLE: in=0 -> DATA. Latch lsb_first for the whole frame and clear the bit counter. in=1 -> stay.
- DATA: shift in one bit per enabled edge. lsb_first=1 shifts right, inserting at the MSB, so the first bit ends in bit 0. lsb_first=0 shifts left, inserting at bit 0, so the first bit ends in the MSB. After DATA_WIDTH bits -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP, in=1: data_out<=assembled word; valid<=1; frame_cnt<=frame_cnt+1.
  - parity_err<=1 if (XOR of data bits ^ parity bit) != PARITY_ODD.
  - -> IDLE.
- STOP, in=0: frame_err<=1; valid=0; data_out, parity_err and frame_cnt unchanged; -> IDLE. The 0 is not treated as a new start bit.
- Strobes: valid and frame_err are high for exactly one clock after the setting edge. They clear on the next rising edge regardless of enable.
- Timing: start bit sampled at enabled edge E0, data at E1..E_DATA_WIDTH, parity at E_DATA_WIDTH+1, stop at E_DATA_WIDTH+2. valid is visible after the stop edge.
- Back-to-back: the next start bit is accepted on the enabled edge immediately after the stop edge, giving 11 enabled cycles per 8-bit frame.
- enable=0: state, counter, shift register and outputs hold, except that strobes still clear. Stalls of any length are transparent.
- lsb_first changes mid-frame are ignored until the next start bit.
- A frame with parity error still asserts valid and increments frame_cnt.
- busy is combinational from state.

Test Plan:
- Even parity, lsb_first=1, enable=1. Send in = 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB first, parity 0, stop). -> valid for 1 cycle after the 11th edge; data_out=0xA5, parity_err=0, frame_cnt=1; busy high for edges 1..10.
- lsb_first=0. Send 0, then 0,0,1,1,1,1,0,0, parity 0, stop 1. -> data_out=0x3C, parity_err=0, frame_cnt increments.
- 0xA5 LSB first with parity bit 1. -> valid=1, data_out=0xA5, parity_err=1. A following correct frame of 0x0F (parity 0) clears parity_err.
- Stop bit 0 after 0xA5 data. -> frame_err pulses 1 cycle, valid stays 0, data_out keeps its previous value, frame_cnt unchanged, state returns to IDLE. A start bit on the next edge is accepted.
- enable low for 3 cycles after the 4th data bit of 0xA5. -> identical result, valid delayed exactly 3 cycles. Also check 256 frames -> frame_cnt wraps to 0.
- reset=0 asynchronously after the 4th data bit, released 2 cycles later. -> all outputs 0 immediately, busy=0. The next full 0x5A frame yields data_out=0x5A and frame_cnt=1.
